// File: rtl/flash_prog_pkg.sv
// rtl/flash_prog_pkg.sv - shared state encoding and command constants for flash_prog
package flash_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_WLOW      = 3'd2,
        ST_WHIGH     = 3'd3,
        ST_POLL_WAIT = 3'd4,
        ST_POLL_GAP  = 3'd5,
        ST_RST_CMD   = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    // Unlock / command word addresses (halfword addressing)
    localparam logic [22:0] CMD_ADDR_555 = 23'h000555;
    localparam logic [22:0] CMD_ADDR_2AA = 23'h0002AA;
    localparam logic [22:0] CMD_ADDR_000 = 23'h000000;

    // Command data values
    localparam logic [15:0] CMD_AA = 16'h00AA;
    localparam logic [15:0] CMD_55 = 16'h0055;
    localparam logic [15:0] CMD_A0 = 16'h00A0;
    localparam logic [15:0] CMD_80 = 16'h0080;
    localparam logic [15:0] CMD_30 = 16'h0030;
    localparam logic [15:0] CMD_F0 = 16'h00F0;

    // Number of bus write cycles in each command sequence
    localparam logic [2:0] PROG_SEQ_LEN  = 3'd4;
    localparam logic [2:0] ERASE_SEQ_LEN = 3'd6;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - combinational lookup of the program/erase command sequence
module flash_cmd_seq
    import flash_prog_pkg::*;
(
    input  logic        erase_i,
    input  logic [2:0]  idx_i,
    input  logic [22:0] addr_i,
    input  logic [15:0] data_i,
    output logic [22:0] word_o,
    output logic [15:0] data_o,
    output logic        last_o
);

    // Map the sequence index to the (word address, data) pair of that bus write
    always_comb begin
        word_o = addr_i;
        data_o = data_i;
        last_o = 1'b0;
        if (erase_i) begin
            case (idx_i)
                3'd0:    begin word_o = CMD_ADDR_555; data_o = CMD_AA; end
                3'd1:    begin word_o = CMD_ADDR_2AA; data_o = CMD_55; end
                3'd2:    begin word_o = CMD_ADDR_555; data_o = CMD_80; end
                3'd3:    begin word_o = CMD_ADDR_555; data_o = CMD_AA; end
                3'd4:    begin word_o = CMD_ADDR_2AA; data_o = CMD_55; end
                default: begin word_o = addr_i;       data_o = CMD_30; end
            endcase
            last_o = (idx_i >= ERASE_SEQ_LEN - 3'd1);
        end else begin
            case (idx_i)
                3'd0:    begin word_o = CMD_ADDR_555; data_o = CMD_AA; end
                3'd1:    begin word_o = CMD_ADDR_2AA; data_o = CMD_55; end
                3'd2:    begin word_o = CMD_ADDR_555; data_o = CMD_A0; end
                default: begin word_o = addr_i;       data_o = data_i; end
            endcase
            last_o = (idx_i >= PROG_SEQ_LEN - 3'd1);
        end
    end

endmodule

// File: rtl/flash_prog.sv
// rtl/flash_prog.sv - NOR flash halfword program / sector erase sequencer with DQ7 polling
module flash_prog
    import flash_prog_pkg::*;
#(
    parameter int WE_LOW  = 4,
    parameter int WE_HIGH = 2,
    parameter int RD_WAIT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic        erase,
    input  logic [23:0] addr,
    input  logic [15:0] data_in,
    output logic        wt,
    output logic        err,
    output logic        busy,
    output logic        ce_n,
    output logic        byte_n,
    output logic        oe_n,
    output logic        we_n,
    output logic [23:0] a,
    output logic [15:0] d_out,
    output logic        d_oe,
    input  logic [15:0] d_in
);

    localparam int CNT_MAX = max3(WE_LOW, WE_HIGH, RD_WAIT);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LD_WLOW  = CW'(WE_LOW - 1);
    localparam logic [CW-1:0] LD_WHIGH = CW'(WE_HIGH - 1);
    localparam logic [CW-1:0] LD_POLL  = CW'(RD_WAIT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    seq_q, seq_d;
    logic          erase_q, erase_d;
    logic [22:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          f0_q, f0_d;        // current bus write is the F0 reset command
    logic          retry_q, retry_d;  // DQ5 seen: this poll is the last chance
    logic          dq7_q, dq7_d;
    logic          dq5_q, dq5_d;

    logic [22:0]   seq_word;
    logic [15:0]   seq_data;
    logic          seq_last;
    logic          exp_dq7;
    logic          unused_bits;

    assign exp_dq7     = erase_q | data_q[7];
    assign unused_bits = ^{addr[0], d_in[15:8], d_in[6], d_in[4:0]};

    flash_cmd_seq u_cmd_seq (
        .erase_i (erase_q),
        .idx_i   (seq_q),
        .addr_i  (addr_q),
        .data_i  (data_q),
        .word_o  (seq_word),
        .data_o  (seq_data),
        .last_o  (seq_last)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seq_q   <= '0;
            erase_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            f0_q    <= 1'b0;
            retry_q <= 1'b0;
            dq7_q   <= 1'b0;
            dq5_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            erase_q <= erase_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            f0_q    <= f0_d;
            retry_q <= retry_d;
            dq7_q   <= dq7_d;
            dq5_q   <= dq5_d;
        end
    end

    // Next-state: walk the command sequence, then poll DQ7 until done or failed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        erase_d = erase_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        f0_d    = f0_q;
        retry_d = retry_q;
        dq7_d   = dq7_q;
        dq5_d   = dq5_q;
        case (state_q)
            ST_IDLE: begin
                if (en && wr) begin
                    state_d = ST_SETUP;
                    erase_d = erase;
                    addr_d  = addr[23:1];
                    data_d  = data_in;
                    seq_d   = '0;
                    err_d   = 1'b0;
                    f0_d    = 1'b0;
                    retry_d = 1'b0;
                end
            end
            ST_SETUP, ST_RST_CMD: begin
                state_d = ST_WLOW;
                cnt_d   = LD_WLOW;
            end
            ST_WLOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_WHIGH;
                    cnt_d   = LD_WHIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WHIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (f0_q) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (seq_last) begin
                    state_d = ST_POLL_WAIT;
                    cnt_d   = LD_POLL;
                end else begin
                    state_d = ST_SETUP;
                    seq_d   = seq_q + 3'd1;
                end
            end
            ST_POLL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_POLL_GAP;
                    dq7_d   = d_in[7];
                    dq5_d   = d_in[5];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_POLL_GAP: begin
                if (dq7_q == exp_dq7) begin
                    state_d = ST_DONE;
                end else if (retry_q) begin
                    state_d = ST_RST_CMD;
                    f0_d    = 1'b1;
                end else begin
                    state_d = ST_POLL_WAIT;
                    cnt_d   = LD_POLL;
                    retry_d = dq5_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state and latched operands
    always_comb begin
        ce_n   = 1'b0;
        byte_n = 1'b1;
        err    = err_q;
        busy   = (state_q != ST_IDLE);
        wt     = (state_q != ST_DONE);
        we_n   = (state_q != ST_WLOW);
        oe_n   = (state_q != ST_POLL_WAIT);
        d_oe   = 1'b0;
        a      = '0;
        d_out  = '0;
        case (state_q)
            ST_SETUP, ST_WLOW, ST_WHIGH: begin
                d_oe = 1'b1;
                if (f0_q) begin
                    a     = {CMD_ADDR_000, 1'b0};
                    d_out = CMD_F0;
                end else begin
                    a     = {seq_word, 1'b0};
                    d_out = seq_data;
                end
            end
            ST_RST_CMD: begin
                d_oe  = 1'b1;
                a     = {CMD_ADDR_000, 1'b0};
                d_out = CMD_F0;
            end
            ST_POLL_WAIT, ST_POLL_GAP: begin
                a = {addr_q, 1'b0};
            end
            default: begin
                a     = '0;
                d_out = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_prog.sv
// tb/tb_flash_prog.sv - self-checking bench for flash_prog with a behavioural flash model
module tb_flash_prog;

    localparam int WL = 4;
    localparam int WH = 2;
    localparam int RW = 6;

    logic        clk = 1'b0;
    logic        reset, en, wr, erase;
    logic [23:0] addr;
    logic [15:0] data_in;
    logic        wt, err, busy, ce_n, byte_n, oe_n, we_n, d_oe;
    logic [23:0] a;
    logic [15:0] d_out;
    logic [15:0] d_in;

    int vectors = 0;
    int miscompares = 0;

    // monitor state
    logic [23:0] mon_a[$];
    logic [15:0] mon_d[$];
    int          mon_len[$];
    int          mon_olen[$];
    int          wlen = 0, olen = 0, poll_cnt = 0, busywt = 0, wtlow = 0, viol = 0;
    logic        we_prev = 1'b1, oe_prev = 1'b1;

    // flash poll responses, consumed one per poll
    logic [15:0] resp[$];
    logic [15:0] resp_dflt = 16'h0000;
    int          resp_base = 0;

    flash_prog #(.WE_LOW(WL), .WE_HIGH(WH), .RD_WAIT(RW)) dut (
        .clk(clk), .reset(reset), .en(en), .wr(wr), .erase(erase),
        .addr(addr), .data_in(data_in), .wt(wt), .err(err), .busy(busy),
        .ce_n(ce_n), .byte_n(byte_n), .oe_n(oe_n), .we_n(we_n), .a(a),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        int idx;
        #1;
        if (!we_n && we_prev) begin
            mon_a.push_back(a);
            mon_d.push_back(d_out);
            wlen = 1;
        end else if (!we_n) begin
            wlen++;
        end else if (!we_prev) begin
            mon_len.push_back(wlen);
        end
        if (!oe_n) olen++;
        if (oe_n && !oe_prev) begin
            poll_cnt++;
            mon_olen.push_back(olen);
            olen = 0;
        end
        if (!we_n && !d_oe) viol++;
        if (!oe_n && d_oe) viol++;
        if (ce_n !== 1'b0 || byte_n !== 1'b1 || a[0] !== 1'b0) viol++;
        if (busy && wt) busywt++;
        if (!wt) wtlow++;
        we_prev = we_n;
        oe_prev = oe_n;
        idx  = poll_cnt - resp_base;
        d_in = (idx < resp.size()) ? resp[idx] : resp_dflt;
    end

    task automatic run_op(input logic er, input logic [23:0] ad, input logic [15:0] dt,
                          input bit scramble, input string tag);
        logic [23:0] ea[$];
        logic [15:0] ed[$];
        logic [15:0] r;
        logic        e7, eerr, got_err;
        int          np, i, bw, bl, bp, bo, bb, bt, bv, nw;
        bit          done, seen_busy, fin;
        e7 = er ? 1'b1 : dt[7];
        resp_dflt = {8'h00, e7, 7'h00};
        ea.push_back(24'h000AAA); ed.push_back(16'h00AA);
        ea.push_back(24'h000554); ed.push_back(16'h0055);
        if (er) begin
            ea.push_back(24'h000AAA); ed.push_back(16'h0080);
            ea.push_back(24'h000AAA); ed.push_back(16'h00AA);
            ea.push_back(24'h000554); ed.push_back(16'h0055);
            ea.push_back(ad & 24'hFFFFFE); ed.push_back(16'h0030);
        end else begin
            ea.push_back(24'h000AAA); ed.push_back(16'h00A0);
            ea.push_back(ad & 24'hFFFFFE); ed.push_back(dt);
        end
        // poll outcome from the DQ7/DQ5 rules
        np = 0; i = 0; eerr = 1'b0; fin = 0;
        while (!fin) begin
            r = (i < resp.size()) ? resp[i] : resp_dflt;
            np++; i++;
            if (r[7] == e7) begin
                fin = 1;
            end else if (r[5]) begin
                r = (i < resp.size()) ? resp[i] : resp_dflt;
                np++; i++;
                if (r[7] != e7) begin
                    eerr = 1'b1;
                    ea.push_back(24'h000000); ed.push_back(16'h00F0);
                end
                fin = 1;
            end
        end
        bw = mon_a.size(); bl = mon_len.size(); bp = poll_cnt; bo = mon_olen.size();
        bb = busywt; bt = wtlow; bv = viol;
        resp_base = poll_cnt;
        @(negedge clk);
        erase = er; addr = ad; data_in = dt; wr = 1'b1; en = 1'b1;
        done = 0; seen_busy = 0; got_err = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (scramble) begin
                addr = $urandom; data_in = $urandom; erase = $urandom;
            end
            if (busy === 1'b1 && !seen_busy) begin
                seen_busy = 1;
                vectors++;
                if (err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s err_cleared_at_start: got %b want 0", tag, err);
                end
            end
            if (wt === 1'b0) begin
                got_err = err;
                en = 1'b0;
                done = 1;
            end
        end
        en = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: wt never went low", tag);
        end
        nw = mon_a.size() - bw;
        vectors++;
        if (nw != ea.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", tag, nw, ea.size());
        end
        for (int k = 0; k < nw && k < ea.size(); k++) begin
            vectors++;
            if (mon_a[bw+k] !== ea[k] || mon_d[bw+k] !== ed[k] || mon_len[bl+k] != WL) begin
                miscompares++;
                $display("FAIL %s write%0d: got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                         tag, k, mon_a[bw+k], mon_d[bw+k], mon_len[bl+k], ea[k], ed[k], WL);
            end
        end
        vectors++;
        if (poll_cnt - bp != np) begin
            miscompares++;
            $display("FAIL %s poll_count: got %0d want %0d", tag, poll_cnt - bp, np);
        end
        for (int k = bo; k < mon_olen.size(); k++) begin
            vectors++;
            if (mon_olen[k] != RW) begin
                miscompares++;
                $display("FAIL %s oe_low_len: got %0d want %0d", tag, mon_olen[k], RW);
            end
        end
        vectors++;
        if (busywt - bb != ea.size() * (1 + WL + WH) + np * (RW + 1)) begin
            miscompares++;
            $display("FAIL %s busy_time: got %0d want %0d", tag, busywt - bb,
                     ea.size() * (1 + WL + WH) + np * (RW + 1));
        end
        vectors++;
        if (wtlow - bt != 1) begin
            miscompares++;
            $display("FAIL %s wt_low_cycles: got %0d want 1", tag, wtlow - bt);
        end
        vectors++;
        if (got_err !== eerr) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", tag, got_err, eerr);
        end
        vectors++;
        if (viol != bv) begin
            miscompares++;
            $display("FAIL %s pin_rules: got %0d violations want 0", tag, viol - bv);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b0; wr = 1'b0; erase = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({wt, err, busy, we_n, oe_n, d_oe} !== 6'b100110) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100110", {wt, err, busy, we_n, oe_n, d_oe});
        end
        vectors++;
        if (a !== 24'h0 || d_out !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got a=%h d=%h want 0 0", a, d_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_program;
        resp.delete(); resp.push_back(16'h0080); resp.push_back(16'h0080);
        run_op(1'b0, 24'h000124, 16'h5A3C, 0, "program");
    endtask

    task automatic test_erase;
        resp.delete(); resp.push_back(16'h0080);
        run_op(1'b1, 24'h020000, 16'h1234, 0, "erase");
    endtask

    task automatic test_dq5_fail;
        resp.delete(); resp.push_back(16'h0020); resp.push_back(16'h0020);
        run_op(1'b0, 24'h000356, 16'h0080, 0, "dq5_fail");
        resp.delete(); resp.push_back(16'h0020);
        run_op(1'b0, 24'h000400, 16'h0000, 0, "dq5_recover");
    endtask

    task automatic test_reset_mid;
        int b, wb;
        bit hit;
        resp.delete();
        b = mon_a.size(); hit = 0;
        @(negedge clk);
        erase = 1'b0; addr = 24'h000888; data_in = 16'h00FF; wr = 1'b1; en = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (mon_a.size() - b >= 3) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_reach: third write not seen");
        end
        @(negedge clk);
        reset = 1'b1; en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({we_n, d_oe, wt, busy} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_mid_pins: got %b want 1010", {we_n, d_oe, wt, busy});
        end
        reset = 1'b0;
        wb = mon_a.size();
        repeat (12) @(negedge clk);
        vectors++;
        if (mon_a.size() != wb || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d writes busy=%b want 0 writes busy=0",
                     mon_a.size() - wb, busy);
        end
        resp.push_back(16'h0000);
        run_op(1'b0, 24'h000888, 16'h00FF, 0, "after_reset");
    endtask

    task automatic test_ignore_read;
        @(negedge clk);
        en = 1'b1; wr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            erase = $urandom; addr = $urandom; data_in = $urandom;
            @(negedge clk);
            vectors++;
            if ({we_n, oe_n, d_oe, busy, wt} !== 5'b11001) begin
                miscompares++;
                $display("FAIL ignore_read cyc%0d: got %b want 11001", c, {we_n, oe_n, d_oe, busy, wt});
            end
        end
        en = 1'b0;
    endtask

    task automatic test_scramble;
        resp.delete(); resp.push_back(16'h0000);
        run_op(1'b0, 24'h00ABCE, 16'hC3A5, 1, "scramble_prog");
        resp.delete(); resp.push_back(16'h0000); resp.push_back(16'h0020);
        run_op(1'b1, 24'h7F0000, 16'h0000, 1, "scramble_erase");
    endtask

    task automatic test_random;
        int n;
        for (int t = 0; t < 10; t++) begin
            resp.delete();
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) resp.push_back(16'($urandom) & 16'h00A0);
            run_op(1'($urandom), 24'($urandom), 16'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_erase();
        test_dq5_fail();
        test_reset_mid();
        test_ignore_read();
        test_scramble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
